// File: rtl/zipdbg_pkg.sv
// Shared constants for the multi-core ZipCPU debug controller: bus register map,
// control/status bit positions and the step sequencer state encoding.
package zipdbg_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_STEPS  = 2'd3;

  localparam int CTRL_RESET = 6;
  localparam int CTRL_STEP  = 8;
  localparam int CTRL_READY = 9;
  localparam int CTRL_HALT  = 10;
  localparam int CTRL_CLRPF = 11;
  localparam int CTRL_CC    = 12;
  localparam int CTRL_BREAK = 16;

  localparam int STAT_SEL    = 0;
  localparam int STAT_MASK   = 8;
  localparam int STAT_STICKY = 16;
  localparam int STAT_HALT   = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } step_state_t;

endpackage

// File: rtl/zipdbg_if.sv
// Wishbone debug slave bus between the host and the debug controller.
interface zipdbg_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;

  modport master (output cyc, stb, we, addr, wdata, input ack, stall, rdata);
  modport slave  (input cyc, stb, we, addr, wdata, output ack, stall, rdata);
endinterface

// File: rtl/zipdbg_stepper.sv
// Counted single-step sequencer: releases halt on one latched core for one cycle
// per step and waits for that core to become ready before the next step.
module zipdbg_stepper
  import zipdbg_pkg::*;
#(
  parameter int LGNCPU     = 2,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LGNCPU-1:0]     i_core,
  input  logic                  i_abort,
  input  logic                  i_load,
  input  logic [STEP_WIDTH-1:0] i_load_val,
  input  logic                  i_stall,
  input  logic                  i_break,
  output logic                  o_release,
  output logic                  o_busy,
  output logic [LGNCPU-1:0]     o_core,
  output logic [STEP_WIDTH-1:0] o_count
);

  step_state_t           state_reg;
  logic [STEP_WIDTH-1:0] count_reg;
  logic [LGNCPU-1:0]     core_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      core_reg  <= '0;
    end else begin
      if (i_load)
        count_reg <= i_load_val;
      if (i_abort) begin
        state_reg <= ST_IDLE;
      end else if (i_start) begin
        state_reg <= ST_PULSE;
        core_reg  <= i_core;
        if (count_reg == '0)
          count_reg <= STEP_WIDTH'(1);
      end else begin
        case (state_reg)
          ST_PULSE: state_reg <= i_break ? ST_IDLE : ST_WAIT;
          ST_WAIT: begin
            // A completed step always counts; a break while waiting keeps the count.
            if (!i_stall) begin
              count_reg <= count_reg - STEP_WIDTH'(1);
              state_reg <= (count_reg == STEP_WIDTH'(1) || i_break) ? ST_IDLE : ST_PULSE;
            end else if (i_break) begin
              state_reg <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_release = (state_reg == ST_PULSE);
  assign o_busy    = (state_reg != ST_IDLE);
  assign o_core    = core_reg;
  assign o_count   = count_reg;

endmodule

// File: rtl/zipdbg_ctrl.sv
// Multi-core debug controller: one wishbone slave steering halt, reset, step,
// cache clear and register access for NCPU cores, with break latches and interrupt.
module zipdbg_ctrl
  import zipdbg_pkg::*;
#(
  parameter int NCPU         = 4,
  parameter int LGNCPU       = 2,
  parameter bit START_HALTED = 1'b0,
  parameter int STEP_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  zipdbg_if.slave              dbg,
  output logic [NCPU-1:0]      o_cpu_reset,
  output logic [NCPU-1:0]      o_cpu_halt,
  output logic [NCPU-1:0]      o_cpu_clear_cache,
  output logic [NCPU-1:0]      o_cpu_dbg_we,
  output logic [4:0]           o_cpu_dbg_addr,
  output logic [31:0]          o_cpu_dbg_data,
  input  logic [NCPU-1:0]      i_cpu_dbg_stall,
  input  logic [32*NCPU-1:0]   i_cpu_dbg_data,
  input  logic [4*NCPU-1:0]    i_cpu_dbg_cc,
  input  logic [NCPU-1:0]      i_cpu_break,
  output logic                 o_int
);

  localparam int NPAD = 1 << LGNCPU;

  logic [LGNCPU-1:0] sel_reg;
  logic [NCPU-1:0]   mask_reg, sticky_reg, halt_reg, reset_reg, clrpf_reg;
  logic [NCPU-1:0]   halt_next, sticky_next;
  logic [4:0]        regaddr_reg;
  logic              ack_reg, int_reg;

  // Per-core views padded to a power of two so an out-of-range select reads 0.
  logic [NPAD-1:0]   stall_pad, break_pad, halt_pad, sticky_pad, reset_pad;
  logic [NPAD-1:0]   sel_onehot_pad, step_onehot_pad;
  logic [31:0]       data_pad [NPAD];
  logic [3:0]        cc_pad   [NPAD];
  logic [NCPU-1:0]   sel_onehot, release_mask;

  logic accept, wr, ctrl_wr, data_wr, status_wr, steps_wr;
  logic step_release, step_busy, step_stall, step_break;
  logic [LGNCPU-1:0]     step_core;
  logic [STEP_WIDTH-1:0] step_count;

  generate
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
      if (gi < NCPU) begin : g_core
        assign data_pad[gi] = i_cpu_dbg_data[32*gi +: 32];
        assign cc_pad[gi]   = i_cpu_dbg_cc[4*gi +: 4];
      end else begin : g_none
        assign data_pad[gi] = '0;
        assign cc_pad[gi]   = '0;
      end
    end
  endgenerate

  always_comb begin
    stall_pad  = '0;
    break_pad  = '0;
    halt_pad   = '0;
    sticky_pad = '0;
    reset_pad  = '0;
    stall_pad[NCPU-1:0]  = i_cpu_dbg_stall;
    break_pad[NCPU-1:0]  = i_cpu_break;
    halt_pad[NCPU-1:0]   = halt_reg;
    sticky_pad[NCPU-1:0] = sticky_reg;
    reset_pad[NCPU-1:0]  = reset_reg;
  end

  assign sel_onehot_pad  = {{(NPAD-1){1'b0}}, 1'b1} << sel_reg;
  assign step_onehot_pad = {{(NPAD-1){1'b0}}, 1'b1} << step_core;
  assign sel_onehot      = sel_onehot_pad[NCPU-1:0];
  assign release_mask    = step_release ? step_onehot_pad[NCPU-1:0] : '0;

  assign dbg.stall = dbg.stb && (dbg.addr == ADDR_DATA) && stall_pad[sel_reg];
  assign accept    = dbg.cyc && dbg.stb && !dbg.stall;
  assign wr        = accept && dbg.we;
  assign ctrl_wr   = wr && (dbg.addr == ADDR_CTRL);
  assign data_wr   = wr && (dbg.addr == ADDR_DATA);
  assign status_wr = wr && (dbg.addr == ADDR_STATUS);
  assign steps_wr  = wr && (dbg.addr == ADDR_STEPS);

  assign step_stall = stall_pad[step_core];
  assign step_break = break_pad[step_core];

  zipdbg_stepper #(
    .LGNCPU     (LGNCPU),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_stepper (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (ctrl_wr && dbg.wdata[CTRL_STEP]),
    .i_core     (sel_reg),
    .i_abort    (ctrl_wr && !dbg.wdata[CTRL_STEP]),
    .i_load     (steps_wr),
    .i_load_val (dbg.wdata[STEP_WIDTH-1:0]),
    .i_stall    (step_stall),
    .i_break    (step_break),
    .o_release  (step_release),
    .o_busy     (step_busy),
    .o_core     (step_core),
    .o_count    (step_count)
  );

  // A host CTRL write beats a simultaneous break for halt; break still latches sticky.
  always_comb begin
    halt_next = halt_reg | i_cpu_break;
    if (ctrl_wr)
      halt_next = (halt_next & ~sel_onehot)
                | (sel_onehot & {NCPU{dbg.wdata[CTRL_HALT] | dbg.wdata[CTRL_STEP]}});
    sticky_next = i_cpu_break
                | (sticky_reg & ~(status_wr ? dbg.wdata[STAT_STICKY +: NCPU] : {NCPU{1'b0}}));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_reg     <= '0;
      mask_reg    <= '0;
      sticky_reg  <= '0;
      halt_reg    <= {NCPU{START_HALTED}};
      reset_reg   <= '1;
      clrpf_reg   <= '0;
      regaddr_reg <= '0;
      ack_reg     <= 1'b0;
      int_reg     <= 1'b0;
    end else begin
      ack_reg    <= accept;
      reset_reg  <= (ctrl_wr && dbg.wdata[CTRL_RESET]) ? sel_onehot : '0;
      clrpf_reg  <= (ctrl_wr && dbg.wdata[CTRL_CLRPF]) ? sel_onehot : '0;
      halt_reg   <= halt_next;
      sticky_reg <= sticky_next;
      int_reg    <= |(sticky_reg & mask_reg);
      if (ctrl_wr)
        regaddr_reg <= dbg.wdata[4:0];
      if (status_wr) begin
        sel_reg  <= dbg.wdata[STAT_SEL +: LGNCPU];
        mask_reg <= dbg.wdata[STAT_MASK +: NCPU];
      end
    end
  end

  always_comb begin
    dbg.rdata = '0;
    case (dbg.addr)
      ADDR_CTRL: begin
        dbg.rdata[4:0]           = regaddr_reg;
        dbg.rdata[CTRL_RESET]    = reset_pad[sel_reg];
        dbg.rdata[CTRL_STEP]     = step_busy;
        dbg.rdata[CTRL_READY]    = !stall_pad[sel_reg];
        dbg.rdata[CTRL_HALT]     = halt_pad[sel_reg];
        dbg.rdata[CTRL_CC +: 4]  = cc_pad[sel_reg];
        dbg.rdata[CTRL_BREAK]    = sticky_pad[sel_reg];
      end
      ADDR_DATA: dbg.rdata = data_pad[sel_reg];
      ADDR_STATUS: begin
        dbg.rdata[STAT_SEL +: LGNCPU]  = sel_reg;
        dbg.rdata[STAT_MASK +: NCPU]   = mask_reg;
        dbg.rdata[STAT_STICKY +: NCPU] = sticky_reg;
        dbg.rdata[STAT_HALT +: NCPU]   = halt_reg;
      end
      default: dbg.rdata[STEP_WIDTH-1:0] = step_count;
    endcase
  end

  assign dbg.ack           = ack_reg;
  assign o_cpu_reset       = reset_reg;
  assign o_cpu_halt        = i_rst ? '1 : (halt_reg & ~release_mask);
  assign o_cpu_clear_cache = clrpf_reg;
  assign o_cpu_dbg_we      = (data_wr && !i_rst) ? sel_onehot : '0;
  assign o_cpu_dbg_addr    = regaddr_reg;
  assign o_cpu_dbg_data    = dbg.wdata;
  assign o_int             = int_reg;

endmodule

// File: tb/tb_zipdbg_ctrl.sv
// Directed bench for zipdbg_ctrl (4 cores, START_HALTED=1): register vector table
// plus hand sequences for stalling, stepping, break, interrupt and reset.
module tb_zipdbg_ctrl;
  import zipdbg_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   cpu_reset, cpu_halt, cpu_clear_cache, cpu_dbg_we;
  logic [4:0]   cpu_dbg_addr;
  logic [31:0]  cpu_dbg_data;
  logic [3:0]   cpu_stall = '0;
  logic [127:0] cpu_data;
  logic [15:0]  cpu_cc = 16'hA5C3;
  logic [3:0]   cpu_break = '0;
  logic         irq;

  zipdbg_if dbg_bus();

  zipdbg_ctrl #(.NCPU(4), .LGNCPU(2), .START_HALTED(1'b1), .STEP_WIDTH(16)) dut (
    .i_clk (clk), .i_rst (rst), .dbg (dbg_bus.slave),
    .o_cpu_reset (cpu_reset), .o_cpu_halt (cpu_halt), .o_cpu_clear_cache (cpu_clear_cache),
    .o_cpu_dbg_we (cpu_dbg_we), .o_cpu_dbg_addr (cpu_dbg_addr), .o_cpu_dbg_data (cpu_dbg_data),
    .i_cpu_dbg_stall (cpu_stall), .i_cpu_dbg_data (cpu_data), .i_cpu_dbg_cc (cpu_cc),
    .i_cpu_break (cpu_break), .o_int (irq)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  // Core-1 environment model: stall held 2 cycles after each release, optional break.
  logic model_on = 1'b0;
  int   rel_cnt = 0, cur_run = 0, max_run = 0, stall1_cnt = 0, break_after = 0, stall2_cnt = 0;
  logic [3:0]  last_we;
  logic [31:0] last_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        chk;
    string       name;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cpu_break = '0;
    if (stall2_cnt > 0) begin
      stall2_cnt--;
      if (stall2_cnt == 0) cpu_stall[2] = 1'b0;
    end
    if (model_on) begin
      if (!cpu_halt[1]) begin
        rel_cnt++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        cpu_stall[1] = 1'b1;
        stall1_cnt = 2;
      end else begin
        cur_run = 0;
        if (stall1_cnt > 0) begin
          stall1_cnt--;
          if (stall1_cnt == 0) cpu_stall[1] = 1'b0;
          if (break_after != 0 && rel_cnt == break_after && stall1_cnt == 1) cpu_break[1] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int waited);
    dbg_bus.cyc = 1'b1; dbg_bus.stb = 1'b1; dbg_bus.we = we;
    dbg_bus.addr = a; dbg_bus.wdata = d;
    waited = 0;
    #1;
    while (dbg_bus.stall && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      checks++; failures++;
      $display("FAIL bus_stall_timeout: got stalled expected accept");
    end
    last_we = cpu_dbg_we;
    last_wdata = cpu_dbg_data;
    tick();
    dbg_bus.stb = 1'b0;
    #1;
    check("bus_ack", {31'd0, dbg_bus.ack}, 32'd1);
    rd = dbg_bus.rdata;
    dbg_bus.cyc = 1'b0;
    $display("txn %s addr=%0d wdata=%h rdata=%h waited=%0d", we ? "WR" : "RD", a, d, rd, waited);
  endtask

  logic [31:0] rd;
  int w, n;

  initial begin
    for (int k = 0; k < 4; k++) cpu_data[32*k +: 32] = 32'hC0DE_0000 | k;
    dbg_bus.cyc = 0; dbg_bus.stb = 0; dbg_bus.we = 0; dbg_bus.addr = 0; dbg_bus.wdata = 0;

    vecs[0]  = '{1'b0, ADDR_STATUS, 32'h0,          32'h0F00_0000, 1'b1, "status_rst"};
    vecs[1]  = '{1'b0, ADDR_STEPS,  32'h0,          32'h0000_0000, 1'b1, "steps_rst"};
    vecs[2]  = '{1'b1, ADDR_STEPS,  32'h0001_2345,  32'h0,         1'b0, "steps_wr"};
    vecs[3]  = '{1'b0, ADDR_STEPS,  32'h0,          32'h0000_2345, 1'b1, "steps_trunc"};
    vecs[4]  = '{1'b1, ADDR_STEPS,  32'h0,          32'h0,         1'b0, "steps_clr"};
    vecs[5]  = '{1'b1, ADDR_STATUS, 32'hFFFF_FF03,  32'h0,         1'b0, "status_wr"};
    vecs[6]  = '{1'b0, ADDR_STATUS, 32'h0,          32'h0F00_0F03, 1'b1, "status_fields"};
    vecs[7]  = '{1'b0, ADDR_CTRL,   32'h0,          32'h0000_A600, 1'b1, "ctrl_core3"};
    vecs[8]  = '{1'b1, ADDR_CTRL,   32'h0000_001F,  32'h0,         1'b0, "ctrl_unhalt3"};
    vecs[9]  = '{1'b0, ADDR_CTRL,   32'h0,          32'h0000_A21F, 1'b1, "ctrl_core3_run"};
    vecs[10] = '{1'b0, ADDR_STATUS, 32'h0,          32'h0700_0F03, 1'b1, "status_haltvec"};
    vecs[11] = '{1'b0, ADDR_DATA,   32'h0,          32'hC0DE_0003, 1'b1, "data_core3"};
    vecs[12] = '{1'b1, ADDR_STATUS, 32'h0,          32'h0,         1'b0, "status_zero"};
    vecs[13] = '{1'b0, ADDR_STATUS, 32'h0,          32'h0700_0000, 1'b1, "status_sel0"};
    vecs[14] = '{1'b0, ADDR_CTRL,   32'h0,          32'h0000_361F, 1'b1, "ctrl_core0"};
    vecs[15] = '{1'b0, ADDR_STEPS,  32'h0,          32'h0000_0000, 1'b1, "steps_zero"};

    // Reset
    repeat (3) tick();
    check("halt_in_rst", {28'd0, cpu_halt}, 32'hF);
    rst = 1'b0;
    check("reset_pulse", {28'd0, cpu_reset}, 32'hF);
    tick();
    check("reset_done", {28'd0, cpu_reset}, 32'h0);
    check("halt_after_rst", {28'd0, cpu_halt}, 32'hF);
    check("int_rst", {31'd0, irq}, 32'd0);
    check("ack_rst", {31'd0, dbg_bus.ack}, 32'd0);

    foreach (vecs[i]) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, w);
      if (vecs[i].chk) check(vecs[i].name, rd, vecs[i].exp);
    end

    // Reset and cache-clear pulses on core 0
    bus(1'b1, ADDR_CTRL, 32'h0000_0C40, rd, w);
    check("cpu_reset_pulse", {28'd0, cpu_reset}, 32'h1);
    check("clrpf_pulse", {28'd0, cpu_clear_cache}, 32'h1);
    tick();
    check("cpu_reset_end", {28'd0, cpu_reset}, 32'h0);
    check("clrpf_end", {28'd0, cpu_clear_cache}, 32'h0);

    // DATA write strobe
    bus(1'b1, ADDR_DATA, 32'h1234_5678, rd, w);
    check("dbg_we_accept", {28'd0, last_we}, 32'h1);
    check("dbg_wdata", last_wdata, 32'h1234_5678);
    check("dbg_we_after", {28'd0, cpu_dbg_we}, 32'h0);

    // DATA read stalled 3 cycles on core 2
    bus(1'b1, ADDR_STATUS, 32'h2, rd, w);
    bus(1'b1, ADDR_CTRL, 32'h0000_0405, rd, w);
    cpu_stall[2] = 1'b1; stall2_cnt = 3;
    bus(1'b0, ADDR_DATA, 32'h0, rd, w);
    check("stall_cycles", w, 32'd3);
    check("data_core2", rd, 32'hC0DE_0002);
    check("dbg_addr", {27'd0, cpu_dbg_addr}, 32'h5);

    // Three-step sequence on core 1
    bus(1'b1, ADDR_STATUS, 32'h1, rd, w);
    bus(1'b1, ADDR_STEPS, 32'd3, rd, w);
    model_on = 1'b1; cpu_stall[1] = 1'b1; rel_cnt = 0; max_run = 0; break_after = 0;
    bus(1'b1, ADDR_CTRL, 32'h0000_0100, rd, w);
    n = 0;
    do begin bus(1'b0, ADDR_CTRL, 32'h0, rd, w); n++; end while (rd[8] && n < 40);
    if (n >= 40) begin checks++; failures++; $display("FAIL step3_timeout: got busy expected idle"); end
    check("step3_pulses", rel_cnt, 32'd3);
    check("step3_width", max_run, 32'd1);
    bus(1'b0, ADDR_STEPS, 32'h0, rd, w);
    check("step3_steps", rd, 32'd0);
    bus(1'b0, ADDR_CTRL, 32'h0, rd, w);
    check("step3_busy", {31'd0, rd[8]}, 32'd0);
    check("step3_halt", {31'd0, cpu_halt[1]}, 32'd1);

    // Ten-step sequence broken during second wait
    bus(1'b1, ADDR_STEPS, 32'd10, rd, w);
    rel_cnt = 0; break_after = 2;
    bus(1'b1, ADDR_CTRL, 32'h0000_0100, rd, w);
    n = 0;
    do begin bus(1'b0, ADDR_CTRL, 32'h0, rd, w); n++; end while (rd[8] && n < 40);
    if (n >= 40) begin checks++; failures++; $display("FAIL brk_timeout: got busy expected idle"); end
    check("brk_pulses", rel_cnt, 32'd2);
    bus(1'b0, ADDR_STEPS, 32'h0, rd, w);
    check("brk_steps", rd, 32'd9);
    check("brk_halt", {31'd0, cpu_halt[1]}, 32'd1);
    bus(1'b0, ADDR_STATUS, 32'h0, rd, w);
    check("brk_sticky", {31'd0, rd[17]}, 32'd1);
    model_on = 1'b0; break_after = 0; repeat (3) tick(); cpu_stall[1] = 1'b0;

    // Interrupt from masked break on core 1
    bus(1'b1, ADDR_STATUS, 32'h0002_0001, rd, w);
    bus(1'b0, ADDR_STATUS, 32'h0, rd, w);
    check("sticky_clear", rd, 32'h0700_0001);
    bus(1'b1, ADDR_CTRL, 32'h0, rd, w);
    check("unhalt1", {31'd0, cpu_halt[1]}, 32'd0);
    bus(1'b1, ADDR_STATUS, 32'h0000_0201, rd, w);
    tick(); tick();
    check("int_idle", {31'd0, irq}, 32'd0);
    cpu_break[1] = 1'b1;
    tick(); tick();
    check("int_set", {31'd0, irq}, 32'd1);
    check("break_halt", {31'd0, cpu_halt[1]}, 32'd1);
    bus(1'b0, ADDR_STATUS, 32'h0, rd, w);
    check("status_break", rd, 32'h0702_0201);
    bus(1'b1, ADDR_STATUS, 32'h0002_0201, rd, w);
    tick(); tick();
    check("int_clear", {31'd0, irq}, 32'd0);

    // Reset in the middle of a release pulse
    bus(1'b1, ADDR_STEPS, 32'd5, rd, w);
    model_on = 1'b1; cpu_stall[1] = 1'b1; rel_cnt = 0;
    bus(1'b1, ADDR_CTRL, 32'h0000_0100, rd, w);
    n = 0;
    while (rel_cnt < 1 && n < 20) begin tick(); n++; end
    check("rst_pulse_seen", rel_cnt, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_halt_forced", {28'd0, cpu_halt}, 32'hF);
    check("rst_cpu_reset", {28'd0, cpu_reset}, 32'hF);
    rst = 1'b0;
    tick();
    check("rst_halt_start", {28'd0, cpu_halt}, 32'hF);
    repeat (10) tick();
    check("rst_no_release", rel_cnt, 32'd1);
    model_on = 1'b0; cpu_stall[1] = 1'b0;
    bus(1'b0, ADDR_STEPS, 32'h0, rd, w);
    check("rst_steps", rd, 32'd0);
    bus(1'b0, ADDR_CTRL, 32'h0, rd, w);
    check("rst_busy", {31'd0, rd[8]}, 32'd0);
    bus(1'b0, ADDR_STATUS, 32'h0, rd, w);
    check("rst_status", rd, 32'h0F00_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
